// File: rtl/ll8_arb2_if.sv
// rtl/ll8_arb2_if.sv - ll8 bus bundle for the two-source arbiter: two source ports and one output port
interface ll8_arb2_if;
  logic [7:0] data0_i;
  logic       sof0_i;
  logic       eof0_i;
  logic       error0_i;
  logic       src_rdy0_i;
  logic       dst_rdy0_o;

  logic [7:0] data1_i;
  logic       sof1_i;
  logic       eof1_i;
  logic       error1_i;
  logic       src_rdy1_i;
  logic       dst_rdy1_o;

  logic [7:0] dataout;
  logic       sof_o;
  logic       eof_o;
  logic       error_o;
  logic       src_rdy_o;
  logic       dst_rdy_i;
  logic [1:0] grant_o;

  // arbiter side
  modport slave (
    input  data0_i, sof0_i, eof0_i, error0_i, src_rdy0_i,
    output dst_rdy0_o,
    input  data1_i, sof1_i, eof1_i, error1_i, src_rdy1_i,
    output dst_rdy1_o,
    output dataout, sof_o, eof_o, error_o, src_rdy_o, grant_o,
    input  dst_rdy_i
  );

  // sources and downstream consumer side
  modport master (
    output data0_i, sof0_i, eof0_i, error0_i, src_rdy0_i,
    input  dst_rdy0_o,
    output data1_i, sof1_i, eof1_i, error1_i, src_rdy1_i,
    input  dst_rdy1_o,
    input  dataout, sof_o, eof_o, error_o, src_rdy_o, grant_o,
    output dst_rdy_i
  );
endinterface

// File: rtl/ll8_arb2.sv
// rtl/ll8_arb2.sv - two-source frame-atomic ll8 arbiter, round-robin on ties
// LL8_ARB2_FIXED_PRIO_EN: when defined, ties always go to port 0
module ll8_arb2 (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  ll8_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   last_nxt;
  logic   tie_pick1;

`ifdef LL8_ARB2_FIXED_PRIO_EN
  assign tie_pick1 = 1'b0;
`else
  // last holds the port served most recently, so the other one wins a tie
  assign tie_pick1 = ~last;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else if (clear) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    bus.dataout    = 8'h00;
    bus.sof_o      = 1'b0;
    bus.eof_o      = 1'b0;
    bus.error_o    = 1'b0;
    bus.src_rdy_o  = 1'b0;
    bus.dst_rdy0_o = 1'b0;
    bus.dst_rdy1_o = 1'b0;
    bus.grant_o    = 2'b00;
    case (state)
      IDLE: begin
        if (bus.src_rdy0_i && bus.src_rdy1_i) begin
          state_nxt = tie_pick1 ? GNT1 : GNT0;
        end else if (bus.src_rdy0_i) begin
          state_nxt = GNT0;
        end else if (bus.src_rdy1_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        bus.dataout    = bus.data0_i;
        bus.sof_o      = bus.sof0_i;
        bus.eof_o      = bus.eof0_i;
        bus.error_o    = bus.error0_i;
        bus.src_rdy_o  = bus.src_rdy0_i;
        bus.dst_rdy0_o = bus.dst_rdy_i;
        bus.grant_o    = 2'b01;
        // ownership ends only when the eof beat actually transfers
        if (bus.src_rdy0_i && bus.dst_rdy_i && bus.eof0_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      GNT1: begin
        bus.dataout    = bus.data1_i;
        bus.sof_o      = bus.sof1_i;
        bus.eof_o      = bus.eof1_i;
        bus.error_o    = bus.error1_i;
        bus.src_rdy_o  = bus.src_rdy1_i;
        bus.dst_rdy1_o = bus.dst_rdy_i;
        bus.grant_o    = 2'b10;
        if (bus.src_rdy1_i && bus.dst_rdy_i && bus.eof1_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ll8_arb2.sv
// tb/tb_ll8_arb2.sv - bench for ll8_arb2: vector table, tie/gap sequence, random backpressure scoreboard
module tb_ll8_arb2;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  ll8_arb2_if bus ();

  ll8_arb2 dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       s0;
    logic [7:0] d0;
    logic [2:0] f0;
    logic       s1;
    logic [7:0] d1;
    logic [2:0] f1;
    logic       drdy;
    logic       clr;
    logic [15:0] exp_o;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  vec_t  vt[$];
  beat_t src_q [2][$];
  beat_t exp_q [2][$];
  int    seqn [2];
  int    m_owner;
  int    m_last;
  int    cur_src;
  int    cyc;
  int    sof_src[$];
  int    sof_cyc[$];
  int    eof_cyc[$];

  function automatic logic [15:0] pack_o(input logic [1:0] g, input logic sr, input logic [7:0] d,
                                         input logic [2:0] f, input logic r0, input logic r1);
    return {g, sr, d, f, r0, r1};
  endfunction

  function automatic logic [15:0] outs();
    return {bus.grant_o, bus.src_rdy_o, bus.dataout, bus.sof_o, bus.eof_o, bus.error_o,
            bus.dst_rdy0_o, bus.dst_rdy1_o};
  endfunction

  task automatic add_vec(input logic s0, input logic [7:0] d0, input logic [2:0] f0,
                         input logic s1, input logic [7:0] d1, input logic [2:0] f1,
                         input logic drdy, input logic clr, input logic [15:0] e);
    vec_t v;
    v.s0 = s0; v.d0 = d0; v.f0 = f0;
    v.s1 = s1; v.d1 = d1; v.f1 = f1;
    v.drdy = drdy; v.clr = clr; v.exp_o = e;
    vt.push_back(v);
  endtask

  task automatic drive(input logic s0, input logic [7:0] d0, input logic [2:0] f0,
                       input logic s1, input logic [7:0] d1, input logic [2:0] f1,
                       input logic drdy, input logic clr);
    bus.src_rdy0_i = s0; bus.data0_i = d0;
    {bus.sof0_i, bus.eof0_i, bus.error0_i} = f0;
    bus.src_rdy1_i = s1; bus.data1_i = d1;
    {bus.sof1_i, bus.eof1_i, bus.error1_i} = f1;
    bus.dst_rdy_i = drdy;
    clear = clr;
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    drive(0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 0, 1);
    @(posedge clk); #1;
    clear = 1'b0;
    m_owner = -1;
    m_last  = 1;
    cur_src = -1;
    sof_src.delete(); sof_cyc.delete(); eof_cyc.delete();
    cyc = 0;
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = {p[0], seqn[p][6:0]};
      b.sof = (i == 0);
      b.eof = (i == len - 1);
      b.err = ($urandom_range(7) == 0);
      seqn[p]++;
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  // Drives both sources from their queues, checks every cycle against a
  // spec-level owner model and every delivered byte against per-source order.
  task automatic run(input int valid_pct, input int drdy_pct, input int budget);
    int    n;
    logic  s [2];
    beat_t b [2];
    logic  drdy;
    logic [15:0] e;
    beat_t got;
    int    p;
    n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0) && n < budget) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        b[k] = '{8'h00, 1'b0, 1'b0, 1'b0};
        if (src_q[k].size() != 0) b[k] = src_q[k][0];
        s[k] = (src_q[k].size() != 0) && ($urandom_range(99) < valid_pct);
      end
      drdy = ($urandom_range(99) < drdy_pct);
      drive(s[0], b[0].d, {b[0].sof, b[0].eof, b[0].err},
            s[1], b[1].d, {b[1].sof, b[1].eof, b[1].err}, drdy, 0);
      #4;
      if (m_owner < 0) e = '0;
      else if (m_owner == 0) e = pack_o(2'b01, s[0], b[0].d, {b[0].sof, b[0].eof, b[0].err}, drdy, 1'b0);
      else e = pack_o(2'b10, s[1], b[1].d, {b[1].sof, b[1].eof, b[1].err}, 1'b0, drdy);
      check16($sformatf("model cyc%0d", cyc), outs(), e);

      if (bus.src_rdy_o && bus.dst_rdy_i) begin
        got = '{bus.dataout, bus.sof_o, bus.eof_o, bus.error_o};
        p = int'(bus.dataout[7]);
        checks++;
        if (exp_q[p].size() == 0) begin
          errors++;
          $display("FAIL sb_extra cyc%0d got=%h expected=none", cyc, bus.dataout);
        end else begin
          if (got !== exp_q[p][0]) begin
            errors++;
            $display("FAIL sb_order cyc%0d got=%h/%b%b%b expected=%h/%b%b%b", cyc,
                     got.d, got.sof, got.eof, got.err,
                     exp_q[p][0].d, exp_q[p][0].sof, exp_q[p][0].eof, exp_q[p][0].err);
          end
          void'(exp_q[p].pop_front());
        end
        if (cur_src >= 0) check_int($sformatf("interleave cyc%0d", cyc), p, cur_src);
        if (got.sof) begin
          sof_src.push_back(p);
          sof_cyc.push_back(cyc);
        end
        cur_src = got.eof ? -1 : p;
        if (got.eof) eof_cyc.push_back(cyc);
      end

      for (int k = 0; k < 2; k++)
        if (s[k] && m_owner == k && drdy) void'(src_q[k].pop_front());

      if (m_owner < 0) begin
        if (s[0] && s[1]) begin
`ifdef LL8_ARB2_FIXED_PRIO_EN
          m_owner = 0;
`else
          m_owner = (m_last == 0) ? 1 : 0;
`endif
        end else if (s[0]) m_owner = 0;
        else if (s[1]) m_owner = 1;
      end else if (s[m_owner] && drdy && b[m_owner].eof) begin
        m_last  = m_owner;
        m_owner = -1;
      end
      n++;
      cyc++;
    end
    check_int("run_budget_left0", src_q[0].size(), 0);
    check_int("run_budget_left1", src_q[1].size(), 0);
    check_int("sb_undelivered0", exp_q[0].size(), 0);
    check_int("sb_undelivered1", exp_q[1].size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seqn[0] = 0;
    seqn[1] = 0;
    reset = 1'b0;
    drive(0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 0, 0);
    #12;
    check16("reset_outputs", outs(), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;

    // sof/eof/err flag triple is {sof, eof, err}
    add_vec(0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 1, 0, 16'h0000);
    add_vec(1, 8'h11, 3'b100, 0, 8'h00, 3'b000, 1, 0, 16'h0000);
    add_vec(1, 8'h11, 3'b100, 0, 8'h00, 3'b000, 1, 0, pack_o(2'b01, 1, 8'h11, 3'b100, 1, 0));
    add_vec(1, 8'h22, 3'b000, 0, 8'h00, 3'b000, 1, 0, pack_o(2'b01, 1, 8'h22, 3'b000, 1, 0));
    add_vec(1, 8'h33, 3'b001, 0, 8'h00, 3'b000, 1, 0, pack_o(2'b01, 1, 8'h33, 3'b001, 1, 0));
    add_vec(1, 8'h44, 3'b010, 0, 8'h00, 3'b000, 1, 0, pack_o(2'b01, 1, 8'h44, 3'b010, 1, 0));
    add_vec(0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 1, 0, 16'h0000);
    add_vec(1, 8'h55, 3'b100, 0, 8'h00, 3'b000, 1, 0, 16'h0000);
    add_vec(1, 8'h55, 3'b100, 1, 8'hA1, 3'b100, 1, 0, pack_o(2'b01, 1, 8'h55, 3'b100, 1, 0));
    add_vec(1, 8'h66, 3'b000, 1, 8'hA1, 3'b100, 1, 0, pack_o(2'b01, 1, 8'h66, 3'b000, 1, 0));
    for (int i = 0; i < 3; i++)
      add_vec(0, 8'h77, 3'b010, 1, 8'hA1, 3'b100, 1, 0, pack_o(2'b01, 0, 8'h77, 3'b010, 1, 0));
    add_vec(1, 8'h77, 3'b010, 1, 8'hA1, 3'b100, 1, 0, pack_o(2'b01, 1, 8'h77, 3'b010, 1, 0));
    add_vec(0, 8'h00, 3'b000, 1, 8'hA1, 3'b110, 1, 0, 16'h0000);
    add_vec(0, 8'h00, 3'b000, 1, 8'hA1, 3'b110, 1, 0, pack_o(2'b10, 1, 8'hA1, 3'b110, 0, 1));
    add_vec(0, 8'h00, 3'b000, 1, 8'hB1, 3'b100, 1, 0, 16'h0000);
    add_vec(0, 8'h00, 3'b000, 1, 8'hB1, 3'b100, 0, 0, pack_o(2'b10, 1, 8'hB1, 3'b100, 0, 0));
    add_vec(0, 8'h00, 3'b000, 1, 8'hB1, 3'b100, 1, 0, pack_o(2'b10, 1, 8'hB1, 3'b100, 0, 1));
    add_vec(0, 8'h00, 3'b000, 1, 8'hB2, 3'b001, 1, 1, pack_o(2'b10, 1, 8'hB2, 3'b001, 0, 1));
    add_vec(1, 8'hC1, 3'b110, 1, 8'hD1, 3'b110, 1, 0, 16'h0000);
    add_vec(1, 8'hC1, 3'b110, 1, 8'hD1, 3'b110, 1, 0, pack_o(2'b01, 1, 8'hC1, 3'b110, 1, 0));
    add_vec(1, 8'hC1, 3'b110, 1, 8'hD1, 3'b110, 1, 0, 16'h0000);
`ifdef LL8_ARB2_FIXED_PRIO_EN
    add_vec(1, 8'hC1, 3'b110, 1, 8'hD1, 3'b110, 1, 0, pack_o(2'b01, 1, 8'hC1, 3'b110, 1, 0));
`else
    add_vec(1, 8'hC1, 3'b110, 1, 8'hD1, 3'b110, 1, 0, pack_o(2'b10, 1, 8'hD1, 3'b110, 0, 1));
`endif
    add_vec(0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 0, 0, 16'h0000);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(vt[i].s0, vt[i].d0, vt[i].f0, vt[i].s1, vt[i].d1, vt[i].f1, vt[i].drdy, vt[i].clr);
      #4;
      check16($sformatf("vec%0d", i), outs(), vt[i].exp_o);
    end

    // continuous tie with 2-beat frames: order and one idle cycle between frames
    do_clear();
    for (int i = 0; i < 4; i++) begin
      add_frame(0, 2);
      add_frame(1, 2);
    end
    run(100, 100, 200);
    check_int("tie_frames", sof_src.size(), 8);
    if (sof_src.size() >= 4 && eof_cyc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
`ifdef LL8_ARB2_FIXED_PRIO_EN
        check_int($sformatf("tie_src%0d", k), sof_src[k], 0);
`else
        check_int($sformatf("tie_src%0d", k), sof_src[k], k % 2);
`endif
        check_int($sformatf("tie_len%0d", k), eof_cyc[k], sof_cyc[k] + 1);
        if (k < 3) check_int($sformatf("tie_gap%0d", k), sof_cyc[k + 1], eof_cyc[k] + 2);
      end
    end

    // random frames with random src_rdy and dst_rdy toggling
    do_clear();
    for (int i = 0; i < 100; i++) add_frame($urandom_range(1), $urandom_range(1, 64));
    run(80, 60, 40000);
    check_int("rand_frames", sof_src.size(), 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ll8_arb2.md
# ll8_arb2

Two-input, frame-atomic arbiter for the 8-bit LocalLink (ll8) byte stream: data, sof, eof, error, src_rdy/dst_rdy. It shares one downstream ll8 consumer, such as an ll8 short FIFO feeding the GEMAC TX path, between two independent frame sources. Once a source is granted, it owns the output until its eof beat transfers. Grants alternate round-robin so that neither source can starve the other.

## Interface
Parameters:
- none; bus width fixed at 8 data bits plus sof/eof/error flags

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear, active-high; same effect as reset
- data0_i  in  8  port 0 data
- sof0_i, eof0_i, error0_i  in  1 each  port 0 flags
- src_rdy0_i  in  1  port 0 has a valid beat
- dst_rdy0_o  out  1  port 0 beat accepted this cycle when src_rdy0_i is also high
- data1_i, sof1_i, eof1_i, error1_i, src_rdy1_i, dst_rdy1_o  port 1, same meanings as port 0
- dataout  out  8  output data
- sof_o, eof_o, error_o  out  1 each  output flags
- src_rdy_o  out  1  output beat valid
- dst_rdy_i  in  1  downstream ready
- grant_o  out  2  one-hot current owner (bit0 = port 0); 00 when idle

## Operation
- A beat transfers on a port when that port's src_rdy and dst_rdy are both high in the same cycle.
- The FSM has three states: IDLE, GNT0 and GNT1.
- In IDLE:
  - All outputs are 0: src_rdy_o, dst_rdy0_o, dst_rdy1_o, dataout, all flags, grant_o.
  - If only one port has src_rdy high, move to that port's GNT state.
  - If both ports have src_rdy high, grant the port that is not `last`.
  - `last` is a 1-bit register recording the most recently granted port; its reset value is 1, so port 0 wins the first tie.
- In GNTn:
  - Port n's data and flags drive the outputs combinationally.
  - src_rdy_o equals src_rdyn_i.
  - dst_rdyn_o equals dst_rdy_i.
  - The other port's dst_rdy is 0.
- Leaving GNTn:
  - On a transfer with eofn_i high, go to IDLE and set last to n.
  - Otherwise remain in GNTn, including while the source deasserts src_rdy mid-frame.
- sof is not checked. A beat arriving at IDLE without sof is granted and passed through unchanged.
- A single-beat frame (sof and eof both high) transfers and returns to IDLE in the same cycle.
- error is passed through unmodified and has no effect on arbitration.
- reset or clear forces IDLE with last = 1, regardless of state.
  - A clear mid-frame truncates that frame: downstream never sees its eof.
  - The source is expected to be cleared together with the arbiter.

## Timing
- Grant latency: a request seen in IDLE at cycle t is granted at t+1. The first beat can transfer at t+1.
- Data path latency within a grant: 0 cycles, purely combinational mux. There are no registers on the data path.
- There is one idle cycle between back-to-back frames: the eof transfers at t, the next grant is taken at t+1, and the next data transfers at t+2.
- Peak throughput for a frame of L beats is L beats per L+1 cycles.
- dst_rdy_i may toggle at any time. Beats are held until accepted, so none are lost or duplicated.
- The outputs are registered-state-decoded and depend combinationally only on grant state plus the granted port's inputs. There is no path from dst_rdy_i to src_rdy_o.

## Configuration
- LL8_ARB2_FIXED_PRIO_EN:
  - Defined: ties in IDLE always go to port 0, and `last` is ignored. Port 1 is served only when port 0 is idle at the decision cycle.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- Reset release, no requests: all outputs are 0 and grant_o = 00.
- Single source:
  - Stimulus: port 0 sends a 4-beat frame 0x11, 0x22, 0x33, 0x44 (sof on the first beat, eof on the last) with dst_rdy_i = 1.
  - Required: grant_o = 01 from the cycle after the request. The 4 beats appear on dataout over 4 consecutive cycles with flags intact. Then back to IDLE.
- Tie:
  - Stimulus: both ports request continuously with 2-beat frames.
  - Required (default build): output frame order is port 0, port 1, port 0, port 1, with one idle cycle between frames.
  - Required (with LL8_ARB2_FIXED_PRIO_EN): every frame is from port 0.
- Atomicity:
  - Stimulus: port 1 requests while port 0 is mid-frame and port 0 stalls src_rdy0_i for 3 cycles.
  - Required: grant_o stays 01 and dst_rdy1_o stays 0 until port 0's eof transfers.
- Backpressure:
  - Stimulus: toggle dst_rdy_i pseudo-randomly during 100 frames of random length 1..64 from both ports.
  - Required: the scoreboard shows each source's bytes in order, with no interleaving within a frame.
- Clear mid-frame:
  - Stimulus: assert clear while in GNT1.
  - Required: IDLE on the next cycle and all outputs 0. After clear deasserts, a tie grants port 0 first.
